// File: rtl/bayer_quad_colour_proc_if.sv
// Raw Bayer pixel stream in, one processed pixel per 2x2 quad out.
interface bayer_quad_colour_proc_if #(
   parameter int DATA_W = 12
);
   logic [DATA_W-1:0] iDATA;
   logic              iDVAL;
   logic              iSOF;
   logic [1:0]        iMODE;
   logic [DATA_W-1:0] oRed;
   logic [DATA_W-1:0] oGreen;
   logic [DATA_W-1:0] oBlue;
   logic              oDVAL;
   logic [9:0]        oX;
   logic [9:0]        oY;

   modport master (
      output iDATA, iDVAL, iSOF, iMODE,
      input  oRed, oGreen, oBlue, oDVAL, oX, oY
   );

   modport slave (
      input  iDATA, iDVAL, iSOF, iMODE,
      output oRed, oGreen, oBlue, oDVAL, oX, oY
   );
endinterface

// File: rtl/bayer_quad_colour_proc.sv
// Bayer quad reducer: line buffer, 2x2 colour mapping, then
// per-frame RGB / average grey / luma / inverted grey output.
module bayer_quad_colour_proc #(
   parameter int DATA_W      = 12,
   parameter int LINE_W      = 640,
   parameter int BAYER_PHASE = 0
) (
   input logic iCLK,
   input logic iRST,
   bayer_quad_colour_proc_if.slave bus
);
   localparam int GW = DATA_W + 1;
   localparam int SW = DATA_W + 2;
   localparam int LW = DATA_W + 8;
   localparam logic [10:0]       X_LAST = 11'(LINE_W - 1);
   localparam logic [DATA_W-1:0] MAXV   = '1;

   logic [10:0]       x_q, x_d, y_q, y_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] lb_q [LINE_W];
   logic [DATA_W-1:0] lb_d [LINE_W];
   logic [DATA_W-1:0] cur_dly_q, cur_dly_d;
   logic [DATA_W-1:0] prv_dly_q, prv_dly_d;
   logic              s1_vld_q, s1_vld_d;
   logic [DATA_W-1:0] s1_r_q, s1_r_d, s1_b_q, s1_b_d;
   logic [GW-1:0]     s1_g_q, s1_g_d;
   logic [1:0]        s1_mode_q, s1_mode_d;
   logic [9:0]        s1_qx_q, s1_qx_d, s1_qy_q, s1_qy_d;
   logic [DATA_W-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
   logic              dval_q, dval_d;
   logic [9:0]        ox_q, ox_d, oy_q, oy_d;

   logic [DATA_W-1:0] p00, p01, p10, p11;
   logic              done;
   logic [SW-1:0]     sum;
   logic [LW-1:0]     luma;
   logic [DATA_W-1:0] avg;
   logic              unused_ok;

   assign p00  = prv_dly_q;
   assign p01  = lb_q[LINE_W-1];
   assign p10  = cur_dly_q;
   assign p11  = bus.iDATA;
   assign done = bus.iDVAL & ~bus.iSOF & x_q[0] & y_q[0];

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      mode_d = mode_q;
      if (bus.iSOF) begin
         x_d    = bus.iDVAL ? 11'd1 : 11'd0;
         y_d    = '0;
         mode_d = bus.iMODE;
      end else if (bus.iDVAL) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 11'd1;
         end else begin
            x_d = x_q + 11'd1;
         end
      end
   end

   // Shifting only on iDVAL makes input gaps invisible to the quad.
   always_comb begin
      lb_d      = lb_q;
      cur_dly_d = cur_dly_q;
      prv_dly_d = prv_dly_q;
      if (bus.iDVAL) begin
         lb_d[0] = bus.iDATA;
         for (int i = 1; i < LINE_W; i++) lb_d[i] = lb_q[i-1];
         cur_dly_d = bus.iDATA;
         prv_dly_d = p01;
      end
   end

   always_comb begin
      s1_vld_d  = done;
      s1_r_d    = s1_r_q;
      s1_g_d    = s1_g_q;
      s1_b_d    = s1_b_q;
      s1_mode_d = s1_mode_q;
      s1_qx_d   = s1_qx_q;
      s1_qy_d   = s1_qy_q;
      if (done) begin
         s1_mode_d = mode_q;
         s1_qx_d   = x_q[10:1];
         s1_qy_d   = y_q[10:1];
         case (BAYER_PHASE)
            1: begin
               s1_r_d = p01;
               s1_g_d = GW'(p00) + GW'(p11);
               s1_b_d = p10;
            end
            2: begin
               s1_r_d = p10;
               s1_g_d = GW'(p00) + GW'(p11);
               s1_b_d = p01;
            end
            3: begin
               s1_r_d = p11;
               s1_g_d = GW'(p01) + GW'(p10);
               s1_b_d = p00;
            end
            default: begin
               s1_r_d = p00;
               s1_g_d = GW'(p01) + GW'(p10);
               s1_b_d = p11;
            end
         endcase
      end
   end

   // Luma weights sum to 256 per channel unit, so max in gives max out.
   assign sum  = SW'(s1_r_q) + SW'(s1_g_q) + SW'(s1_b_q);
   assign avg  = sum[SW-1:2];
   assign luma = LW'(s1_r_q) * LW'(77) + LW'(s1_g_q) * LW'(75)
               + LW'(s1_b_q) * LW'(29);
   assign unused_ok = ^{sum[1:0], luma[7:0]};

   always_comb begin
      dval_d = s1_vld_q;
      red_d  = red_q;
      grn_d  = grn_q;
      blu_d  = blu_q;
      ox_d   = ox_q;
      oy_d   = oy_q;
      if (s1_vld_q) begin
         ox_d = s1_qx_q;
         oy_d = s1_qy_q;
         unique case (s1_mode_q)
            2'd0: begin
               red_d = s1_r_q;
               grn_d = s1_g_q[GW-1:1];
               blu_d = s1_b_q;
            end
            2'd1: begin
               red_d = avg;
               grn_d = avg;
               blu_d = avg;
            end
            2'd2: begin
               red_d = luma[LW-1:8];
               grn_d = luma[LW-1:8];
               blu_d = luma[LW-1:8];
            end
            default: begin
               red_d = MAXV - avg;
               grn_d = MAXV - avg;
               blu_d = MAXV - avg;
            end
         endcase
      end
   end

   always_ff @(posedge iCLK) begin
      lb_q      <= lb_d;
      cur_dly_q <= cur_dly_d;
      prv_dly_q <= prv_dly_d;
      s1_r_q    <= s1_r_d;
      s1_g_q    <= s1_g_d;
      s1_b_q    <= s1_b_d;
      s1_mode_q <= s1_mode_d;
      s1_qx_q   <= s1_qx_d;
      s1_qy_q   <= s1_qy_d;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         x_q      <= '0;
         y_q      <= '0;
         mode_q   <= '0;
         s1_vld_q <= 1'b0;
         dval_q   <= 1'b0;
         red_q    <= '0;
         grn_q    <= '0;
         blu_q    <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         mode_q   <= mode_d;
         s1_vld_q <= s1_vld_d;
         dval_q   <= dval_d;
         red_q    <= red_d;
         grn_q    <= grn_d;
         blu_q    <= blu_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
      end
   end

   assign bus.oRed   = red_q;
   assign bus.oGreen = grn_q;
   assign bus.oBlue  = blu_q;
   assign bus.oDVAL  = dval_q;
   assign bus.oX     = ox_q;
   assign bus.oY     = oy_q;
endmodule
